// File: rtl/sdmdl_pkg.sv
// sdmdl_pkg: definitions shared by the SD card bench models.
// CRC16 step, bus-width encodings and receive state encoding.
`default_nettype none

package sdmdl_pkg;

    localparam int              NCRC           = 16;
    localparam logic [NCRC-1:0] CRC_POLYNOMIAL = 16'h1021;

    localparam logic [1:0] W1 = 2'b00;
    localparam logic [1:0] W4 = 2'b01;
    localparam logic [1:0] W8 = 2'b10;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_DATA   = 3'd1,
        RX_CRC    = 3'd2,
        RX_STOP   = 3'd3,
        RX_REPORT = 3'd4
    } rx_state_t;

    // One MSB-first shift of the CRC16 register with one serial input bit.
    function automatic logic [NCRC-1:0] STEPCRC(input logic [NCRC-1:0] crc, input logic din);
        logic [NCRC-1:0] nxt;
        nxt = {crc[NCRC-2:0], 1'b0};
        if (crc[NCRC-1] ^ din)
            nxt = nxt ^ CRC_POLYNOMIAL;
        return nxt;
    endfunction

    function automatic logic [7:0] lane_mask(input logic [1:0] width);
        logic [7:0] m;
        case (width)
            W1:      m = 8'h01;
            W4:      m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

    // Sampling cycles per 32-bit word, minus one.
    function automatic logic [4:0] word_beats(input logic [1:0] width);
        logic [4:0] b;
        case (width)
            W1:      b = 5'd31;
            W4:      b = 5'd7;
            default: b = 5'd3;
        endcase
        return b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mdl_sdcrc_lane.sv
// mdl_sdcrc_lane: single-lane CRC16 register; generates over data bits,
// then shifts out its MSB for comparison against the received CRC bits.
`default_nettype none

module mdl_sdcrc_lane
    import sdmdl_pkg::*;
(
    input  logic sd_clk,
    input  logic rst_n,
    input  logic clear,
    input  logic gen,
    input  logic chk,
    input  logic din,
    output logic mismatch
);

    logic [NCRC-1:0] crc;

    always_ff @(posedge sd_clk or negedge rst_n) begin
        if (!rst_n)
            crc <= '0;
        else if (clear)
            crc <= '0;
        else if (gen)
            crc <= STEPCRC(crc, din);
        else if (chk)
            crc <= {crc[NCRC-2:0], 1'b0};
    end

    assign mismatch = chk && (din != crc[NCRC-1]);

endmodule

`default_nettype wire

// File: rtl/mdl_sdrx.sv
// mdl_sdrx: SD card data receive model. Samples host write blocks on sd_dat,
// emits 32-bit words and a one-cycle CRC-status verdict.
`default_nettype none

module mdl_sdrx
    import sdmdl_pkg::*;
#(
    parameter int LGBLK            = 9,
    parameter bit OPT_STRICT_START = 1'b1
) (
    input  logic             rst_n,
    input  logic             sd_clk,
    input  logic [7:0]       sd_dat,
    input  logic             i_en,
    input  logic [1:0]       i_width,
    input  logic [LGBLK:0]   i_len,
    output logic             o_valid,
    output logic [31:0]      o_data,
    output logic             o_last,
    output logic             o_crcack,
    output logic             o_crcnak,
    output logic             o_busy,
    output logic             o_err
);

    rx_state_t        state, state_nx;
    logic [1:0]       width_q;
    logic [7:0]       mask_q, start_mask, start_lanes;
    logic             start_seen, start_partial, len_bad;
    logic             word_done, last_word, stop_bad, crc_bad;
    logic [LGBLK-2:0] len_words, words_left;
    logic [4:0]       beat_cnt;
    logic [3:0]       crc_cnt;
    logic [31:0]      shift_q, shift_nx;
    logic [7:0]       lane_gen, lane_chk, mismatch;

    assign start_mask    = lane_mask(i_width);
    assign start_lanes   = sd_dat & start_mask;
    assign start_seen    = (state == RX_IDLE) && i_en && (start_lanes == 8'h00);
    assign start_partial = (state == RX_IDLE) && i_en && (start_lanes != 8'h00)
                           && (start_lanes != start_mask);
    assign len_bad       = (i_len[1:0] != 2'b00) || (i_len == '0);
    // A sub-word length still yields one word so the block stays framed.
    assign len_words     = (i_len[LGBLK:2] == '0) ? (LGBLK-1)'(1) : i_len[LGBLK:2];
    assign word_done     = (state == RX_DATA) && (beat_cnt == 5'd0);
    assign last_word     = (words_left == (LGBLK-1)'(1));
    assign stop_bad      = ((sd_dat & mask_q) != mask_q);

    always_comb begin
        shift_nx = {shift_q[23:0], sd_dat};
        case (width_q)
            W1:      shift_nx = {shift_q[30:0], sd_dat[0]};
            W4:      shift_nx = {shift_q[27:0], sd_dat[3:0]};
            default: shift_nx = {shift_q[23:0], sd_dat};
        endcase
    end

    always_ff @(posedge sd_clk or negedge rst_n) begin
        if (!rst_n)
            state <= RX_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        lane_gen = 8'h00;
        lane_chk = 8'h00;
        case (state)
            RX_IDLE:   if (start_seen) state_nx = RX_DATA;
            RX_DATA: begin
                lane_gen = mask_q;
                if (word_done && last_word)
                    state_nx = RX_CRC;
            end
            RX_CRC: begin
                lane_chk = mask_q;
                if (crc_cnt == 4'd0)
                    state_nx = RX_STOP;
            end
            RX_STOP:   state_nx = RX_REPORT;
            RX_REPORT: state_nx = RX_IDLE;
            default:   state_nx = RX_IDLE;
        endcase
        if (!i_en) begin
            state_nx = RX_IDLE;
            lane_gen = 8'h00;
            lane_chk = 8'h00;
        end
    end

    for (genvar g = 0; g < 8; g++) begin : g_lane
        mdl_sdcrc_lane u_crc (
            .sd_clk   (sd_clk),
            .rst_n    (rst_n),
            .clear    (start_seen),
            .gen      (lane_gen[g]),
            .chk      (lane_chk[g]),
            .din      (sd_dat[g]),
            .mismatch (mismatch[g])
        );
    end

    always_ff @(posedge sd_clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid    <= 1'b0;
            o_data     <= '0;
            o_last     <= 1'b0;
            o_crcack   <= 1'b0;
            o_crcnak   <= 1'b0;
            o_busy     <= 1'b0;
            o_err      <= 1'b0;
            width_q    <= W1;
            mask_q     <= 8'h01;
            words_left <= '0;
            beat_cnt   <= '0;
            crc_cnt    <= '0;
            shift_q    <= '0;
            crc_bad    <= 1'b0;
        end else begin
            o_valid  <= 1'b0;
            o_last   <= 1'b0;
            o_crcack <= 1'b0;
            o_crcnak <= 1'b0;
            if (!i_en) begin
                o_busy  <= 1'b0;
                o_err   <= 1'b0;
                crc_bad <= 1'b0;
            end else begin
                case (state)
                    RX_IDLE: begin
                        if (start_partial && OPT_STRICT_START)
                            o_err <= 1'b1;
                        if (start_seen) begin
                            width_q    <= i_width;
                            mask_q     <= start_mask;
                            words_left <= len_words;
                            beat_cnt   <= word_beats(i_width);
                            shift_q    <= '0;
                            crc_bad    <= 1'b0;
                            o_busy     <= 1'b1;
                            if (len_bad)
                                o_err <= 1'b1;
                        end
                    end
                    RX_DATA: begin
                        shift_q <= shift_nx;
                        if (beat_cnt == 5'd0) begin
                            o_valid    <= 1'b1;
                            o_data     <= shift_nx;
                            o_last     <= last_word;
                            words_left <= words_left - 1'b1;
                            beat_cnt   <= word_beats(width_q);
                            crc_cnt    <= 4'd15;
                        end else begin
                            beat_cnt <= beat_cnt - 1'b1;
                        end
                    end
                    RX_CRC: begin
                        crc_bad <= crc_bad | (|mismatch);
                        crc_cnt <= crc_cnt - 1'b1;
                    end
                    RX_STOP: begin
                        o_crcack <= !(crc_bad || stop_bad);
                        o_crcnak <= crc_bad || stop_bad;
                    end
                    RX_REPORT: o_busy <= 1'b0;
                    default:   o_busy <= 1'b0;
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mdl_sdrx.sv
// tb_mdl_sdrx: drives SD write blocks built from a lane/bitstream model with
// long-division CRC16, and checks words, timing and CRC verdicts.
`timescale 1ns/1ps
`default_nettype none

module tb_mdl_sdrx;

    logic        rst_n   = 1'b0;
    logic        sd_clk  = 1'b0;
    logic [7:0]  sd_dat  = 8'hFF;
    logic        i_en    = 1'b0;
    logic [1:0]  i_width = 2'b00;
    logic [9:0]  i_len   = 10'd4;
    logic        o_valid, o_last, o_crcack, o_crcnak, o_busy, o_err;
    logic [31:0] o_data;

    mdl_sdrx #(.LGBLK(9), .OPT_STRICT_START(1'b1)) dut (
        .rst_n    (rst_n),
        .sd_clk   (sd_clk),
        .sd_dat   (sd_dat),
        .i_en     (i_en),
        .i_width  (i_width),
        .i_len    (i_len),
        .o_valid  (o_valid),
        .o_data   (o_data),
        .o_last   (o_last),
        .o_crcack (o_crcack),
        .o_crcnak (o_crcnak),
        .o_busy   (o_busy),
        .o_err    (o_err)
    );

    always #5 sd_clk = ~sd_clk;

    int cyc = 0;
    always @(posedge sd_clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [31:0] mq_data[$];
    int          mq_cyc[$];
    bit          mq_last[$];
    int          ack_cyc[$];
    int          nak_cyc[$];
    logic [7:0]  blk[512];

    always @(posedge sd_clk) begin
        #1;
        if (o_valid) begin
            mq_data.push_back(o_data);
            mq_cyc.push_back(cyc);
            mq_last.push_back(o_last);
        end
        if (o_crcack) ack_cyc.push_back(cyc);
        if (o_crcnak) nak_cyc.push_back(cyc);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit bitat(input int b);
        logic [7:0] by;
        by = blk[b >> 3];
        return by[7 - (b & 7)];
    endfunction

    function automatic int lanes_of(input logic [1:0] w);
        return (w == 2'b00) ? 1 : (w == 2'b01) ? 4 : 8;
    endfunction

    // Sends one block; flip_lane/flip_bit corrupt one CRC bit, end_bad zeroes
    // one lane's end bit, abort_after drops i_en after that many data cycles.
    task automatic run_block(input string name, input logic [1:0] w, input int len,
                             input int flip_lane, input int flip_bit,
                             input int end_bad, input int abort_after);
        int L, nw, ncyc, start_cyc, got;
        logic [16:0] rem;
        logic [15:0] crc[8];
        logic [7:0]  mask, v;
        logic [31:0] exp_word;
        bit          good;
        L    = lanes_of(w);
        mask = (L == 1) ? 8'h01 : (L == 4) ? 8'h0F : 8'hFF;
        nw   = len >> 2;
        if (nw == 0) nw = 1;
        ncyc = nw * 32 / L;
        for (int j = 0; j < L; j++) begin
            rem = '0;
            for (int c = 0; c < ncyc + 16; c++) begin
                rem = {rem[15:0], (c < ncyc) ? bitat(c * L + L - 1 - j) : 1'b0};
                if (rem[16]) rem = rem ^ 17'h11021;
            end
            crc[j] = rem[15:0];
        end
        good = (flip_lane < 0) && (end_bad < 0);
        mq_data.delete(); mq_cyc.delete(); mq_last.delete();
        ack_cyc.delete(); nak_cyc.delete();

        i_en = 1'b1; i_width = w; i_len = len[9:0];
        repeat (2) begin @(negedge sd_clk); sd_dat = 8'hFF; end
        @(negedge sd_clk);
        sd_dat    = 8'($urandom) & ~mask;
        start_cyc = cyc + 1;
        for (int c = 0; c < ncyc; c++) begin
            if (c == abort_after) break;
            @(negedge sd_clk);
            i_width = 2'($urandom);
            i_len   = 10'($urandom);
            v = 8'($urandom);
            for (int j = 0; j < L; j++) v[j] = bitat(c * L + L - 1 - j);
            sd_dat = v;
        end
        if (abort_after >= 0) begin
            @(negedge sd_clk);
            i_en = 1'b0; sd_dat = 8'hFF; i_width = w;
            @(posedge sd_clk); #2;
            chk({name, " busy after abort"}, o_busy, 0);
            @(negedge sd_clk);
            i_en = 1'b1;
            repeat (40) @(negedge sd_clk);
            chk({name, " abort word count"}, mq_data.size(), abort_after * L / 32);
            for (int k = 0; k < mq_data.size() && k < abort_after * L / 32; k++) begin
                exp_word = {blk[4*k], blk[4*k+1], blk[4*k+2], blk[4*k+3]};
                chk($sformatf("%s abort word%0d", name, k), mq_data[k], exp_word);
            end
            chk({name, " abort verdicts"}, ack_cyc.size() + nak_cyc.size(), 0);
            return;
        end
        for (int k = 0; k < 16; k++) begin
            @(negedge sd_clk);
            v = 8'($urandom);
            for (int j = 0; j < L; j++)
                v[j] = crc[j][15 - k] ^ ((j == flip_lane) && (15 - k == flip_bit));
            sd_dat = v;
        end
        @(negedge sd_clk);
        chk({name, " busy in block"}, o_busy, 1);
        v = 8'($urandom);
        for (int j = 0; j < L; j++) v[j] = (j != end_bad);
        sd_dat = v;
        repeat (3) begin @(negedge sd_clk); sd_dat = 8'hFF; end
        i_width = w; i_len = len[9:0];

        got = mq_data.size();
        chk({name, " word count"}, got, nw);
        for (int k = 0; k < got && k < nw; k++) begin
            exp_word = {blk[4*k], blk[4*k+1], blk[4*k+2], blk[4*k+3]};
            chk($sformatf("%s word%0d", name, k), mq_data[k], exp_word);
            chk($sformatf("%s word%0d cycle", name, k), mq_cyc[k], start_cyc + (k + 1) * (32 / L));
            chk($sformatf("%s word%0d last", name, k), mq_last[k], (k == nw - 1));
        end
        chk({name, " ack count"}, ack_cyc.size(), good ? 1 : 0);
        chk({name, " nak count"}, nak_cyc.size(), good ? 0 : 1);
        if (good && ack_cyc.size() == 1)
            chk({name, " ack cycle"}, ack_cyc[0], start_cyc + ncyc + 17);
        if (!good && nak_cyc.size() == 1)
            chk({name, " nak cycle"}, nak_cyc[0], start_cyc + ncyc + 17);
        chk({name, " busy after"}, o_busy, 0);
    endtask

    initial begin
        int          w, L, fault;
        logic [31:0] pat;

        repeat (3) @(negedge sd_clk);
        chk("reset valid", o_valid, 0);
        chk("reset data", o_data, 0);
        chk("reset last", o_last, 0);
        chk("reset ack", o_crcack, 0);
        chk("reset nak", o_crcnak, 0);
        chk("reset busy", o_busy, 0);
        chk("reset err", o_err, 0);
        rst_n = 1'b1;
        i_en  = 1'b1;

        // 1b, 512-byte counting pattern
        for (int i = 0; i < 512; i++) blk[i] = 8'(i);
        run_block("t1", 2'b00, 512, -1, 0, -1, -1);

        // 4b, two words
        pat = 32'hDEADBEEF;
        for (int i = 0; i < 4; i++) blk[i] = pat[31 - 8*i -: 8];
        pat = 32'h01234567;
        for (int i = 0; i < 4; i++) blk[4 + i] = pat[31 - 8*i -: 8];
        run_block("t2", 2'b01, 8, -1, 0, -1, -1);

        // 8b, one word, lane 5 CRC bit 3 flipped
        for (int i = 0; i < 4; i++) blk[i] = 8'hA5;
        run_block("t3", 2'b10, 4, 5, 3, -1, -1);

        // 4b, end bit low on lane 2
        for (int i = 0; i < 16; i++) blk[i] = 8'($urandom);
        run_block("t4", 2'b01, 16, -1, 0, 2, -1);

        // 1b abort after 100 bits, then a normal block
        for (int i = 0; i < 64; i++) blk[i] = 8'($urandom);
        run_block("t5a", 2'b00, 64, -1, 0, -1, 100);
        run_block("t5b", 2'b00, 8, -1, 0, -1, -1);
        chk("t5 err clear", o_err, 0);

        // 4b partial start bit
        @(negedge sd_clk);
        i_width = 2'b01; sd_dat = 8'hFE;
        @(negedge sd_clk);
        sd_dat = 8'hFF;
        chk("t6 err set", o_err, 1);
        chk("t6 no busy", o_busy, 0);
        for (int i = 0; i < 8; i++) blk[i] = 8'($urandom);
        run_block("t6b", 2'b01, 8, -1, 0, -1, -1);
        chk("t6 err sticky", o_err, 1);

        // i_en low clears error; non-multiple-of-4 length flags it again
        @(negedge sd_clk); i_en = 1'b0;
        @(negedge sd_clk); i_en = 1'b1;
        chk("err cleared", o_err, 0);
        for (int i = 0; i < 8; i++) blk[i] = 8'($urandom);
        run_block("len6", 2'b01, 6, -1, 0, -1, -1);
        chk("len6 err", o_err, 1);
        @(negedge sd_clk); i_en = 1'b0;
        @(negedge sd_clk); i_en = 1'b1;

        for (int r = 0; r < 8; r++) begin
            w = $urandom_range(0, 3);
            L = lanes_of(2'(w));
            for (int i = 0; i < 64; i++) blk[i] = 8'($urandom);
            fault = $urandom_range(0, 2);
            run_block($sformatf("rnd%0d", r), 2'(w), 4 * $urandom_range(1, 16),
                      (fault == 1) ? $urandom_range(0, L - 1) : -1, $urandom_range(0, 15),
                      (fault == 2) ? $urandom_range(0, L - 1) : -1, -1);
        end
        chk("final err", o_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
